// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared UART definitions (state encoding, default rates, divider formula).
package uart_tx_pkg;

    localparam int unsigned DEF_CLK_FREQ = 100_000_000;
    localparam int unsigned DEF_BAUD     = 9600;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // Clocks per bit; truncating division, RX side uses the same formula.
    function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running bit-period counter, cleared while disabled, ticks on wrap.
module uart_baud_tick #(
    parameter int unsigned BAUD_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam int unsigned CW = $clog2(BAUD_DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick  = en && (cnt_q == CW'(BAUD_DIV - 1));
    assign cnt_d = (!en || tick) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, one byte per valid/ready handshake, LSB first.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
    parameter int unsigned BAUD     = DEF_BAUD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD);

    tx_state_e  state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] idx_q, idx_d;
    logic       tx_q, tx_d, done_q, done_d;
    logic       tick, accept;

    assign tx_ready = (state_q == IDLE);
    assign tx_busy  = (state_q != IDLE);
    assign accept   = tx_valid && tx_ready;
    assign tx       = tx_q;
    assign tx_done  = done_q;

    uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (tx_busy),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE)
            state_d = accept ? START : IDLE;
        else if (tick)
            state_d = (state_q == START) ? DATA :
                      (state_q == DATA)  ? ((idx_q == 3'd7) ? STOP : DATA) : IDLE;
    end

    always_comb begin
        shreg_d = accept ? tx_data : (state_q == DATA && tick) ? (shreg_q >> 1) : shreg_q;
        idx_d   = (state_q != DATA) ? 3'd0 : tick ? idx_q + 3'd1 : idx_q;
    end

    // Line level is computed from the next state so tx stays a plain flop output.
    always_comb begin
        tx_d   = (state_d == START) ? 1'b0 : (state_d == DATA) ? shreg_d[0] : 1'b1;
        done_d = (state_q == STOP) && tick;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx at BAUD_DIV=16 (100/6 truncated) and BAUD_DIV=2.
module tb_uart_tx;
    localparam int D = 16;

    logic       clk, rst_n;
    logic [7:0] tx_data, d2_data;
    logic       tx_valid, tx_ready, tx, tx_busy, tx_done;
    logic       d2_valid, d2_ready, d2_tx, d2_busy, d2_done;
    int         checks = 0;
    int         failures = 0;

    uart_tx #(.CLK_FREQ(100), .BAUD(6)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    uart_tx #(.CLK_FREQ(20), .BAUD(10)) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(d2_data), .tx_valid(d2_valid),
        .tx_ready(d2_ready), .tx(d2_tx), .tx_busy(d2_busy), .tx_done(d2_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic accept_byte(input logic [7:0] b, input logic hold);
        checks++;
        if (tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_ready got=%b exp=1", tx_ready);
        end
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        if (!hold) tx_valid = 1'b0;
    endtask

    // Called at 1ns after the acceptance edge; walks the whole frame clock by clock.
    task automatic expect_frame(input logic [7:0] b, input string name, input logic churn);
        logic [9:0] fr;
        logic [7:0] rx;
        fr = {1'b1, b, 1'b0};
        rx = '0;
        for (int c = 0; c < 10 * D; c++) begin
            if (churn) tx_data = c[0] ? 8'hFF : 8'h00;
            checks++;
            if (tx !== fr[c / D] || tx_busy !== 1'b1 || tx_ready !== 1'b0 || tx_done !== 1'b0) begin
                failures++;
                $display("FAIL %s_line c=%0d got tx=%b busy=%b ready=%b done=%b exp tx=%b busy=1 ready=0 done=0",
                         name, c, tx, tx_busy, tx_ready, tx_done, fr[c / D]);
            end
            if (c % D == D / 2 && c / D >= 1 && c / D <= 8) rx[c / D - 1] = tx;
            @(posedge clk); #1;
        end
        checks++;
        if (rx !== b) begin
            failures++;
            $display("FAIL %s_decode got=%h exp=%h", name, rx, b);
        end
        checks++;
        if (tx_done !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx !== 1'b1) begin
            failures++;
            $display("FAIL %s_end got done=%b ready=%b busy=%b tx=%b exp 1 1 0 1",
                     name, tx_done, tx_ready, tx_busy, tx);
        end
    endtask

    task automatic idle_check(input string name, input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            checks++;
            if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
                failures++;
                $display("FAIL %s_idle c=%0d got tx=%b ready=%b busy=%b done=%b exp 1 1 0 0",
                         name, c, tx, tx_ready, tx_busy, tx_done);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #20;
        checks++;
        if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_vals got tx=%b ready=%b busy=%b done=%b exp 1 1 0 0",
                     tx, tx_ready, tx_busy, tx_done);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_check("reset", 2 * D);
    endtask

    task automatic test_single();
        accept_byte(8'h34, 1'b0);
        expect_frame(8'h34, "single", 1'b0);
        idle_check("single_after", 2 * D);
    endtask

    task automatic test_back_to_back();
        accept_byte(8'h38, 1'b1);
        tx_data = 8'h32;
        expect_frame(8'h38, "b2b_first", 1'b0);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        checks++;
        if (tx !== 1'b0 || tx_ready !== 1'b0 || tx_busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_restart got tx=%b ready=%b busy=%b exp 0 0 1", tx, tx_ready, tx_busy);
        end
        expect_frame(8'h32, "b2b_second", 1'b0);
        idle_check("b2b_after", D);
    endtask

    task automatic test_churn();
        accept_byte(8'hA5, 1'b0);
        expect_frame(8'hA5, "churn", 1'b1);
        idle_check("churn_after", 2 * D);
    endtask

    task automatic test_reset_midframe();
        accept_byte(8'h00, 1'b0);
        repeat (5 * D + D / 2) @(posedge clk);
        #1;
        checks++;
        if (tx !== 1'b0 || tx_busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_bit4 got tx=%b busy=%b exp 0 1", tx, tx_busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset got tx=%b busy=%b ready=%b exp 1 0 1", tx, tx_busy, tx_ready);
        end
        #20;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_release got tx=%b ready=%b busy=%b exp 1 1 0", tx, tx_ready, tx_busy);
        end
        accept_byte(8'h55, 1'b0);
        expect_frame(8'h55, "after_reset", 1'b0);
    endtask

    task automatic test_div2();
        logic [9:0] pat;
        pat = 10'b1100000010;
        checks++;
        if (d2_ready !== 1'b1 || d2_tx !== 1'b1) begin
            failures++;
            $display("FAIL div2_idle got ready=%b tx=%b exp 1 1", d2_ready, d2_tx);
        end
        d2_data  = 8'h81;
        d2_valid = 1'b1;
        @(posedge clk); #1;
        d2_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (d2_tx !== pat[c / 2] || d2_done !== 1'b0 || d2_busy !== 1'b1) begin
                failures++;
                $display("FAIL div2_line c=%0d got tx=%b done=%b busy=%b exp tx=%b done=0 busy=1",
                         c, d2_tx, d2_done, d2_busy, pat[c / 2]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (d2_done !== 1'b1 || d2_ready !== 1'b1 || d2_tx !== 1'b1) begin
            failures++;
            $display("FAIL div2_end got done=%b ready=%b tx=%b exp 1 1 1", d2_done, d2_ready, d2_tx);
        end
        @(posedge clk); #1;
        checks++;
        if (d2_done !== 1'b0 || d2_busy !== 1'b0) begin
            failures++;
            $display("FAIL div2_after got done=%b busy=%b exp 0 0", d2_done, d2_busy);
        end
    endtask

    initial begin
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        d2_data  = 8'h00;
        d2_valid = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_churn();
        test_reset_midframe();
        test_div2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
